// File: rtl/spi_pkg.sv
// Shared definitions for the multi-CS SPI master.
//   state_t   : FSM state encoding (IDLE, SETUP, SHIFT, HOLD, WAIT)
//   cnt_w     : width of a counter/index covering 0..n-1, never below 1 bit
//   bit_cnt_w : width of the per-word bit counter (must be able to hold DATA_W)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_master_mc_if.sv
// Word-side request/response bundle of spi_master_mc.
//   master modport : the client that issues words (drives mode, cs, data, valid)
//   slave modport  : the SPI master block itself (returns ready, rx data, busy)
// Signals:
//   cpol, cpha, lsb_first, cs_sel, cs_hold, valid, data_send : request side
//   ready, data_receive, rx_valid, busy                      : response side
interface spi_master_mc_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CS_NUM = 1
);

  localparam int CS_W = cnt_w(CS_NUM);

  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [CS_W-1:0]   cs_sel;
  logic              cs_hold;
  logic              valid;
  logic [DATA_W-1:0] data_send;
  logic              ready;
  logic [DATA_W-1:0] data_receive;
  logic              rx_valid;
  logic              busy;

  modport master (
    output cpol, cpha, lsb_first, cs_sel, cs_hold, valid, data_send,
    input  ready, data_receive, rx_valid, busy
  );

  modport slave (
    input  cpol, cpha, lsb_first, cs_sel, cs_hold, valid, data_send,
    output ready, data_receive, rx_valid, busy
  );

endinterface

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master.
//   clk, rst : system clock, asynchronous active-low reset
//   clear    : restart the count (asserted on every FSM state change)
//   tick     : high on the last cycle of each DIV-cycle half-period
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            W   = cnt_w(DIV);
  localparam logic [W-1:0]  TOP = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == TOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised SPI master with CS_NUM chip selects, all CPOL/CPHA modes,
// MSB/LSB-first ordering and CS-held bursts.
//   clk, rst      : system clock, asynchronous active-low reset
//   bus (slave)   : word request/response interface (valid/ready handshake)
//   spi_clk       : SCLK
//   spi_mosi      : serial data out
//   spi_miso      : serial data in
//   cs_n          : active-low chip selects
// A word spends DIV cycles in SETUP (skipped inside a burst), 2*DATA_W
// half-periods in SHIFT and DIV cycles in HOLD.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int CS_NUM = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_mc_if.slave    bus,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [CS_NUM-1:0] cs_n
);

  localparam int CS_W = cnt_w(CS_NUM);
  localparam int BCW  = bit_cnt_w(DATA_W);
  localparam int IW   = cnt_w(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  state_t            state, state_nx;
  logic              tick;
  logic              accept;
  logic              lead;
  logic              sample;
  logic              last_edge;
  logic              cpol_q, cpha_q, lsb_q, hold_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_upd;
  logic [BCW-1:0]    bit_cnt;

  // Position of wire-order bit 'idx' inside the parallel word.
  function automatic logic [IW-1:0] bit_pos(input logic [BCW-1:0] idx, input logic lsb);
    return lsb ? IW'(idx) : IW'(DATA_W - 1) - IW'(idx);
  endfunction

  function automatic logic pick_bit(input logic [DATA_W-1:0] w,
                                    input logic [BCW-1:0]    idx,
                                    input logic              lsb);
    return w[bit_pos(idx, lsb)];
  endfunction

  // An out-of-range select matches no bit, so every chip select stays high.
  function automatic logic [CS_NUM-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [CS_NUM-1:0] v;
    v = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (sel == CS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (state_nx != state),
    .tick  (tick)
  );

  assign bus.ready = (state == ST_IDLE) || (state == ST_WAIT);
  assign bus.busy  = (state != ST_IDLE);
  assign accept    = bus.valid && bus.ready;

  // SCLK still at its idle level means the edge about to be made is leading.
  assign lead      = (spi_clk == cpol_q);
  assign sample    = (state == ST_SHIFT) && tick && (lead ^ cpha_q);
  assign last_edge = (state == ST_SHIFT) && tick && !lead && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept)    state_nx = ST_SETUP;
      ST_SETUP: if (tick)      state_nx = ST_SHIFT;
      ST_SHIFT: if (last_edge) state_nx = ST_HOLD;
      ST_HOLD:  if (tick)      state_nx = hold_q ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (accept)    state_nx = ST_SHIFT;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  // The final sample lands on the same edge that enters HOLD, so the
  // received word is taken from the updated value, not from rx_q.
  always_comb begin
    rx_upd = rx_q;
    if (sample) rx_upd[bit_pos(bit_cnt, lsb_q)] = spi_miso;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpol_q           <= 1'b0;
      cpha_q           <= 1'b0;
      lsb_q            <= 1'b0;
      hold_q           <= 1'b0;
      tx_q             <= '0;
      rx_q             <= '0;
      bit_cnt          <= '0;
      spi_clk          <= 1'b0;
      spi_mosi         <= 1'b0;
      cs_n             <= '1;
      bus.data_receive <= '0;
      bus.rx_valid     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;

      if (accept) begin
        tx_q    <= bus.data_send;
        hold_q  <= bus.cs_hold;
        bit_cnt <= '0;
        if (state == ST_IDLE) begin
          // Mode and target are frozen here for the whole burst.
          cpol_q  <= bus.cpol;
          cpha_q  <= bus.cpha;
          lsb_q   <= bus.lsb_first;
          spi_clk <= bus.cpol;
          cs_n    <= cs_decode(bus.cs_sel);
          if (!bus.cpha) spi_mosi <= pick_bit(bus.data_send, '0, bus.lsb_first);
        end else if (!cpha_q) begin
          spi_mosi <= pick_bit(bus.data_send, '0, lsb_q);
        end
      end

      if ((state == ST_SHIFT) && tick) begin
        spi_clk <= ~spi_clk;
        rx_q    <= rx_upd;
        if (lead) begin
          if (cpha_q) spi_mosi <= pick_bit(tx_q, bit_cnt, lsb_q);
        end else begin
          bit_cnt <= bit_cnt + BCW'(1);
          if (!cpha_q && !last_edge) spi_mosi <= pick_bit(tx_q, bit_cnt + BCW'(1), lsb_q);
        end
        if (last_edge) begin
          bus.data_receive <= rx_upd;
          bus.rx_valid     <= 1'b1;
        end
      end

      if ((state == ST_HOLD) && tick && !hold_q) cs_n <= '1;
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc.
// Main instance: DATA_W=8, DIV=4, CS_NUM=4. A transaction-level model derives
// the expected handshake, SCLK, CS and rx behaviour from cycle offsets since
// each accept; an SPI slave model samples MOSI on the mode's sampling edge and
// can supply MISO. Second instance: DATA_W=16, DIV=1 for the fast-clock case.
module tb_spi_master_mc;

  localparam int DW  = 8;
  localparam int DV  = 4;
  localparam int CSN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- DUT 8-bit ----------------
  spi_master_mc_if #(.DATA_W(DW), .CS_NUM(CSN)) bus ();
  logic           spi_clk, spi_mosi, spi_miso;
  logic [CSN-1:0] cs_n;

  spi_master_mc #(.DATA_W(DW), .DIV(DV), .CS_NUM(CSN)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .cs_n     (cs_n)
  );

  // ---------------- DUT 16-bit, DIV=1 ----------------
  spi_master_mc_if #(.DATA_W(16), .CS_NUM(1)) bus16 ();
  logic       spi_clk16, spi_mosi16;
  logic [0:0] cs_n16;

  spi_master_mc #(.DATA_W(16), .DIV(1), .CS_NUM(1)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus16),
    .spi_clk  (spi_clk16),
    .spi_mosi (spi_mosi16),
    .spi_miso (spi_mosi16),
    .cs_n     (cs_n16)
  );

  // ---------------- model state ----------------
  bit         m_in_txn, m_wait, m_setup, m_hold, m_cpol, m_cpha, m_lsb, m_idle_clk;
  int         m_t;
  logic [1:0] m_sel;
  int         m_src;          // 0 loopback, 1 MISO tied high, 2 slave word
  logic [7:0] m_sword;
  logic [7:0] exp_dr;
  logic [7:0] exp_rx_q[$];
  logic [7:0] sent_q[$];
  bit         acc_flag;
  int         src_next;
  logic [7:0] sword_next;
  bit         mosi_watch;
  int         cs0_low, rxv_cnt, rise_cnt;

  bit         e_busy, e_ready, e_clk, e_rxv;
  logic [3:0] e_cs;
  int         s_off, sh_end;
  logic [7:0] popped;

  function automatic logic [3:0] dec(input logic [1:0] sel);
    logic [3:0] v;
    v = 4'hF;
    v[sel] = 1'b0;
    return v;
  endfunction

  // ---------------- slave model ----------------
  int         s_n;
  bit         lead_seen;
  logic [7:0] s_cap;
  logic [2:0] s_idx;

  assign s_idx    = m_lsb ? 3'(s_n) : 3'(7 - s_n);
  assign spi_miso = (m_src == 0) ? spi_mosi : (m_src == 1) ? 1'b1 : m_sword[s_idx];

  task automatic slave_sample();
    s_cap[s_idx] = spi_mosi;
    s_n++;
    if (s_n == DW) begin
      s_n = 0;
      if (sent_q.size() == 0) check("slave_extra_word", 1, 0);
      else check("slave_mosi_word", s_cap, sent_q.pop_front());
    end
  endtask

  always @(spi_clk or negedge rst) begin
    if (!rst) begin
      s_n       = 0;
      lead_seen = 0;
    end else if (spi_clk != m_cpol) begin
      lead_seen = 1;
      if (!m_cpha) slave_sample();
    end else if (lead_seen) begin
      lead_seen = 0;
      if (m_cpha) slave_sample();
    end
  end

  always @(posedge spi_clk) rise_cnt++;

  // ---------------- per-cycle compare + model advance ----------------
  always @(negedge clk) begin
    if (!rst) begin
      m_in_txn = 0; m_wait = 0; m_idle_clk = 0; m_src = 0;
      exp_rx_q.delete(); sent_q.delete();
      exp_dr = '0; acc_flag = 0;
      e_busy = 0; e_ready = 1; e_clk = 0; e_rxv = 0; e_cs = 4'hF;
      check("rst_mosi", spi_mosi, 0);
    end else begin
      s_off  = m_setup ? DV : 0;
      sh_end = s_off + 2 * DW * DV;
      if (m_in_txn) begin
        e_busy = 1; e_ready = 0; e_cs = dec(m_sel);
        e_rxv  = (m_t == sh_end);
        e_clk  = (m_t >= s_off && m_t < sh_end) ?
                 (m_cpol ^ ((((m_t - s_off) / DV) % 2) == 1)) : m_cpol;
        if (e_rxv) begin
          if (exp_rx_q.size() == 0) check("rx_queue_empty", 1, 0);
          else begin popped = exp_rx_q.pop_front(); exp_dr = popped; end
        end
      end else if (m_wait) begin
        e_busy = 1; e_ready = 1; e_cs = dec(m_sel); e_clk = m_cpol; e_rxv = 0;
      end else begin
        e_busy = 0; e_ready = 1; e_cs = 4'hF; e_clk = m_idle_clk; e_rxv = 0;
      end
    end

    check("busy", bus.busy, e_busy);
    check("ready", bus.ready, e_ready);
    check("rx_valid", bus.rx_valid, e_rxv);
    check("spi_clk", spi_clk, e_clk);
    check("cs_n", cs_n, e_cs);
    check("data_receive", bus.data_receive, exp_dr);
    if (mosi_watch) check("mosi_low", spi_mosi, 0);
    if (!cs_n[0]) cs0_low++;
    if (bus.rx_valid) rxv_cnt++;

    if (rst) begin
      acc_flag = bus.valid && e_ready;
      if (m_in_txn) begin
        m_t++;
        if (m_t == sh_end + DV) begin
          m_in_txn = 0;
          m_wait   = m_hold;
        end
      end else if (acc_flag) begin
        if (!m_wait) begin
          m_setup = 1; m_cpol = bus.cpol; m_cpha = bus.cpha; m_lsb = bus.lsb_first;
          m_sel = bus.cs_sel; m_idle_clk = bus.cpol;
        end else begin
          m_setup = 0;
        end
        m_hold  = bus.cs_hold;
        m_src   = src_next;
        m_sword = sword_next;
        exp_rx_q.push_back((src_next == 0) ? bus.data_send :
                           (src_next == 1) ? 8'hFF : sword_next);
        sent_q.push_back(bus.data_send);
        m_in_txn = 1; m_wait = 0; m_t = 0;
      end
    end
  end

  // ---------------- 16-bit instance monitors ----------------
  int busy16, edge16, rxv16;
  logic clk16_prev = 1'b0;
  always @(negedge clk) begin
    if (bus16.busy) busy16++;
    if (spi_clk16 != clk16_prev) edge16++;
    clk16_prev = spi_clk16;
    if (bus16.rx_valid) rxv16++;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input bit pol, input bit pha, input bit lsb,
                      input logic [1:0] sel, input bit hold, input int src,
                      input logic [7:0] sw);
    bit got;
    bus.data_send = d; bus.cpol = pol; bus.cpha = pha; bus.lsb_first = lsb;
    bus.cs_sel = sel; bus.cs_hold = hold; bus.valid = 1'b1;
    src_next = src; sword_next = sw;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      got = acc_flag;
    end
    if (!got) check("accept_timeout", 0, 1);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      done = !m_in_txn && !m_wait;
    end
    if (!done) check("idle_timeout", 0, 1);
    cycles(1);
  endtask

  initial begin
    int         len, edges;
    logic       prev;
    logic [7:0] sw;
    bit         pol, pha, lsb;
    logic [1:0] sel;

    bus.valid = 0; bus.cpol = 0; bus.cpha = 0; bus.lsb_first = 0;
    bus.cs_sel = '0; bus.cs_hold = 0; bus.data_send = '0;
    bus16.valid = 0; bus16.cpol = 0; bus16.cpha = 0; bus16.lsb_first = 0;
    bus16.cs_sel = '0; bus16.cs_hold = 0; bus16.data_send = '0;
    src_next = 0; sword_next = '0; mosi_watch = 0;

    cycles(3);
    check("reset_ready", bus.ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_cs_n", cs_n, 4'hF);
    check("reset_sclk", spi_clk, 0);
    check("reset_rx", bus.data_receive, 0);
    rst = 1;
    cycles(2);

    // Mode 0, MSB-first, A5 on cs 0
    cs0_low = 0; rxv_cnt = 0; rise_cnt = 0;
    send(8'hA5, 0, 0, 0, 2'd0, 0, 0, 8'h00);
    bus.valid = 0;
    wait_idle();
    check("t1_cs_low_cycles", cs0_low, 72);
    check("t1_rising_edges", rise_cnt, 8);
    check("t1_rx_pulses", rxv_cnt, 1);
    check("t1_data", bus.data_receive, 8'hA5);

    // All modes x bit order, loopback then external slave word
    for (int m = 0; m < 4; m++) begin
      for (int l = 0; l < 2; l++) begin
        for (int src = 0; src <= 2; src += 2) begin
          rxv_cnt = 0;
          sw = 8'($urandom);
          send(8'h96, m[1], m[0], l[0], 2'd1, 0, src, sw);
          bus.valid = 0;
          wait_idle();
          check("t2_rx_pulses", rxv_cnt, 1);
          check("t2_data", bus.data_receive, (src == 0) ? 8'h96 : sw);
          check("t2_idle_sclk", spi_clk, m[1]);
        end
      end
    end

    // CS-held burst on cs 2
    rxv_cnt = 0;
    send(8'h11, 0, 0, 0, 2'd2, 1, 0, 8'h00);
    send(8'h22, 0, 0, 0, 2'd2, 1, 0, 8'h00);
    send(8'h33, 0, 0, 0, 2'd2, 0, 0, 8'h00);
    bus.valid = 0;
    wait_idle();
    check("t3_rx_pulses", rxv_cnt, 3);
    check("t3_last_data", bus.data_receive, 8'h33);

    // MISO tied high while sending zeros
    send(8'h00, 0, 0, 0, 2'd0, 0, 1, 8'h00);
    bus.valid = 0;
    mosi_watch = 1;
    wait_idle();
    mosi_watch = 0;
    check("t4_data", bus.data_receive, 8'hFF);

    // Reset on the 5th SCLK edge
    rxv_cnt = 0;
    send(8'h5A, 0, 0, 0, 2'd0, 0, 0, 8'h00);
    bus.valid = 0;
    edges = 0; prev = spi_clk;
    for (int i = 0; i < 500 && edges < 5; i++) begin
      @(posedge clk); #1;
      if (spi_clk != prev) edges++;
      prev = spi_clk;
    end
    check("t5_edges_seen", edges, 5);
    rst = 0;
    #2;
    check("t5_cs_n", cs_n, 4'hF);
    check("t5_ready", bus.ready, 1);
    check("t5_busy", bus.busy, 0);
    cycles(3);
    rst = 1;
    cycles(2);
    check("t5_no_rx_pulse", rxv_cnt, 0);
    send(8'h3C, 0, 0, 0, 2'd0, 0, 0, 8'h00);
    bus.valid = 0;
    wait_idle();
    check("t5_after_reset_data", bus.data_receive, 8'h3C);

    // Random bursts, modes, targets and MISO sources
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, 3);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom); sel = 2'($urandom);
      for (int w = 0; w < len; w++) begin
        // Mode/target inputs change inside a burst but must be ignored.
        if (w > 0) begin
          pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom); sel = 2'($urandom);
        end
        send(8'($urandom), pol, pha, lsb, sel, (w < len - 1), $urandom_range(0, 2),
             8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          bus.valid = 0;
          cycles($urandom_range(0, 3));
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.valid = 0;
        wait_idle();
      end
    end
    bus.valid = 0;
    wait_idle();

    // 16-bit word at DIV=1
    busy16 = 0; edge16 = 0; rxv16 = 0;
    bus16.data_send = 16'hBEEF;
    bus16.valid = 1;
    cycles(1);
    bus16.valid = 0;
    cycles(60);
    check("t6_busy_cycles", busy16, 34);
    check("t6_sclk_edges", edge16, 32);
    check("t6_rx_pulses", rxv16, 1);
    check("t6_data", bus16.data_receive, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
